// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and empty/level logic for the async FIFO.
// Brings the write Gray pointer into the read clock domain and derives the flags from it.
module fifo_rptr_empty #(
  parameter int ADDRESS         = 4,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic               i_r_clk,
  input  logic               i_r_rst,
  input  logic               i_r_inc,
  input  logic [ADDRESS-1:0] i_w_ptr_gray,
  output logic [ADDRESS-2:0] o_r_addr,
  output logic [ADDRESS-1:0] o_r_ptr,
  output logic               o_r_empty,
  output logic               o_r_almost_empty,
  output logic [ADDRESS-1:0] o_r_level
);

  localparam logic [ADDRESS-1:0] TH = ADDRESS'(ALMOST_EMPTY_TH);

  logic [ADDRESS-1:0] r_rq1;
  logic [ADDRESS-1:0] r_rq2;
  logic [ADDRESS-1:0] r_bin;

  logic               w_rd_en;
  logic [ADDRESS-1:0] w_bin_next;
  logic [ADDRESS-1:0] w_gray_next;
  logic [ADDRESS-1:0] w_wbin;
  logic [ADDRESS-1:0] w_diff;

  assign w_rd_en     = i_r_inc & ~o_r_empty;
  assign w_bin_next  = r_bin + {{(ADDRESS-1){1'b0}}, w_rd_en};
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);
  assign w_diff      = w_wbin - w_bin_next;
  assign o_r_addr    = r_bin[ADDRESS-2:0];

  // Gray-to-binary: each bit is the XOR of itself and every bit above it.
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i < ADDRESS; i++) begin
      w_wbin[i] = ^(r_rq2 >> i);
    end
  end

  always_ff @(posedge i_r_clk) begin
    if (i_r_rst) begin
      r_rq1 <= '0;
      r_rq2 <= '0;
    end else begin
      r_rq1 <= i_w_ptr_gray;
      r_rq2 <= r_rq1;
    end
  end

  // Flags use the already-advanced pointer, so a draining read asserts empty on its own edge.
  always_ff @(posedge i_r_clk) begin
    if (i_r_rst) begin
      r_bin            <= '0;
      o_r_ptr          <= '0;
      o_r_empty        <= 1'b1;
      o_r_almost_empty <= 1'b1;
      o_r_level        <= '0;
    end else begin
      r_bin            <= w_bin_next;
      o_r_ptr          <= w_gray_next;
      o_r_empty        <= (w_gray_next == r_rq2);
      o_r_almost_empty <= (w_diff <= TH);
      o_r_level        <= w_diff;
    end
  end

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Randomized bench for fifo_rptr_empty against a count-based model of the read side.
// The model tracks read/write word counts and a two-edge view delay of the write count.
module tb_fifo_rptr_empty;

  logic       clk = 1'b0;
  logic       rst;
  logic       inc;
  logic [3:0] wg;
  logic [2:0] r_addr;
  logic [3:0] r_ptr;
  logic       r_empty;
  logic       r_aempty;
  logic [3:0] r_level;

  int n_checks = 0;
  int n_errors = 0;

  int  wcnt = 0;
  int  rcnt = 0;
  int  h1 = 0;
  int  h2 = 0;
  int  m_level = 0;
  bit  m_empty = 1'b1;
  bit  m_ae = 1'b1;

  fifo_rptr_empty #(.ADDRESS(4), .ALMOST_EMPTY_TH(1)) dut (
    .i_r_clk          (clk),
    .i_r_rst          (rst),
    .i_r_inc          (inc),
    .i_w_ptr_gray     (wg),
    .o_r_addr         (r_addr),
    .o_r_ptr          (r_ptr),
    .o_r_empty        (r_empty),
    .o_r_almost_empty (r_aempty),
    .o_r_level        (r_level)
  );

  always #5 clk = ~clk;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One read-clock cycle: drive on the falling edge, advance the model at the rising edge,
  // then compare every output a moment later.
  task automatic step(input bit r, input bit i, input int w);
    int rd;
    @(negedge clk);
    rst  = r;
    inc  = i;
    wcnt = w & 15;
    wg   = 4'(gray(wcnt));
    @(posedge clk);
    if (r) begin
      rcnt = 0; h1 = 0; h2 = 0;
      m_level = 0; m_empty = 1'b1; m_ae = 1'b1;
    end else begin
      rd      = (i && !m_empty) ? 1 : 0;
      rcnt    = (rcnt + rd) & 15;
      m_level = (h2 - rcnt) & 15;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= 1);
      h2      = h1;
      h1      = wcnt;
    end
    #1;
    chk("addr",   32'(r_addr),   32'(rcnt & 7));
    chk("ptr",    32'(r_ptr),    32'(gray(rcnt)));
    chk("empty",  32'(r_empty),  32'(m_empty));
    chk("aempty", 32'(r_aempty), 32'(m_ae));
    chk("level",  32'(r_level),  32'(m_level));
    chk("level_le_depth", 32'(r_level <= 4'd8), 32'd1);
  endtask

  initial begin
    int w;
    rst = 1'b1; inc = 1'b0; wg = 4'd0;

    step(1, 0, 0);
    step(1, 0, 0);
    chk("reset_empty", 32'(r_empty), 32'd1);
    chk("reset_ptr",   32'(r_ptr),   32'd0);

    // One word written, visible three edges later, then drained by a single read.
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("one_word_level", 32'(r_level), 32'd1);
    chk("one_word_empty", 32'(r_empty), 32'd0);
    step(0, 1, 1);
    chk("drain_ptr",   32'(r_ptr),   32'b0001);
    chk("drain_empty", 32'(r_empty), 32'd1);

    // Reads while empty are ignored.
    for (int k = 0; k < 5; k++) step(0, 1, 1);
    chk("underflow_addr", 32'(r_addr), 32'd1);

    // Fill to full, then drain eight words.
    w = rcnt + 8;
    for (int k = 0; k < 3; k++) step(0, 0, w);
    chk("full_level",  32'(r_level),  32'd8);
    chk("full_aempty", 32'(r_aempty), 32'd0);
    for (int k = 0; k < 8; k++) step(0, 1, w);
    chk("full_drained", 32'(r_empty), 32'd1);

    // Random interleaved traffic; the writer never overfills relative to the read count.
    w = wcnt;
    for (int k = 0; k < 400; k++) begin
      if ((($urandom % 2) == 1) && (((w - rcnt) & 15) < 8)) w = (w + 1) & 15;
      step(0, (($urandom % 3) != 0), w);
    end

    // Reset mid-operation with a read request pending.
    step(1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 5);
    chk("pre_reset_level", 32'(r_level), 32'd5);
    step(1, 1, 5);
    chk("mid_reset_level", 32'(r_level), 32'd0);
    chk("mid_reset_empty", 32'(r_empty), 32'd1);
    for (int k = 0; k < 3; k++) step(0, 0, 5);
    chk("post_reset_level", 32'(r_level), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
